clock_edge_monitor: RTL and testbench
=====================================

// Module: clock_edge_monitor
// PURPOSE
//  Receive-side companion to the clock divider. Samples a divided clock (clk_sample)
//  in the fast clock_in domain through a synchronizer. Emits single-cycle rise and
//  fall strobes for downstream clock-enable logic. Measures the sample-clock period
//  in clock_in cycles and reports lock once that period is stable.
// PARAMETERS
//  SYNC_STAGES  2     synchronizer flops on clk_sample (>=2)
//  CNT_WIDTH    16    width of period counter/outputs
//  LOCK_COUNT   4     consecutive matching periods required to assert locked (>=1)
//  TOLERANCE    0     max |period - ref_period| still counted as a match
//  TIMEOUT      1024  clock_in cycles without a rising edge before declaring loss (< 2^CNT_WIDTH)
// PORTS
//  clock_in      in   1          fast system clock
//  aresetn       in   1          reset, synchronous, active-low
//  clk_sample    in   1          divided clock to monitor (asynchronous to clock_in)
//  rise_strobe   out  1          1-cycle pulse per synchronized rising edge
//  fall_strobe   out  1          1-cycle pulse per synchronized falling edge
//  period        out  CNT_WIDTH  last measured rise-to-rise period, clock_in cycles
//  period_valid  out  1          1-cycle pulse when period is updated
//  ref_period    out  CNT_WIDTH  period currently being locked/held
//  locked        out  1          high while in LOCKED state
//  timeout       out  1          1-cycle pulse when TIMEOUT is reached
// BEHAVIOUR
//  Reset (aresetn low at posedge clock_in):
//   - Sync chain and edge history to 0; cnt, period, ref_period, match_cnt to 0.
//   - All strobes, locked and timeout to 0; state IDLE.
//   - Reset mid-operation discards any partial measurement.
//  Edge detect:
//   - s = last sync flop, s_d = s delayed one cycle.
//   - rise_strobe = s & ~s_d; fall_strobe = ~s & s_d; both registered.
//   - Latency: SYNC_STAGES+1 clock_in cycles from the first sampling edge that sees
//     the new level.
//  Counter:
//   - On a rise cycle: cnt <= 1.
//   - Otherwise: cnt <= cnt+1, saturating at TIMEOUT.
//   - On a rise cycle with first_seen set: period <= cnt and period_valid pulses.
//   - The first rise after reset or timeout only sets first_seen; no period_valid.
//  State machine:
//   - IDLE: on rise -> ACQUIRE (first_seen=1).
//   - ACQUIRE, on each period_valid:
//     - match (|period-ref_period|<=TOLERANCE, computed unsigned with no wrap): match_cnt++.
//     - mismatch: ref_period <= period, match_cnt <= 1.
//     - If match_cnt reaches LOCK_COUNT -> LOCKED. With LOCK_COUNT=1, the first
//       period that matches locks.
//     - The first measured period always mismatches (ref_period starts at 0).
//   - LOCKED:
//     - match: stay; ref_period is held.
//     - mismatch: -> ACQUIRE, ref_period <= period, match_cnt <= 1; locked drops the
//       next cycle.
//   - Any state: cnt == TIMEOUT-1 with no rise this cycle -> timeout pulse, -> IDLE.
//     locked=0, first_seen=0, match_cnt=0; period and ref_period are retained.
//   - A rise in the same cycle as the timeout condition takes priority (no timeout).
//  Outputs locked, period and ref_period are registered and change only on the
//  cycles defined above.
// TESTING
//  1. clk_sample = clock_divider output (period 4 clock_in), TOLERANCE=0
//     -> rise every 4 cycles, period=4.
//     -> locked rises after 1 + LOCK_COUNT(4) periods following the first rise.
//  2. clk_sample held at 0 after lock -> timeout pulses 1024 cycles after the last rise.
//     -> locked=0, state IDLE; the next rise gives no period_valid.
//  3. Locked at 4, then period 6 (TOLERANCE=0) -> locked drops, ref_period=6.
//     -> relock after 4 more periods of 6.
//  4. TOLERANCE=1, periods jitter 7,8,7,8 -> locked stays high, ref_period=first value.
//  5. aresetn low for 1 cycle while locked -> all outputs 0 the next cycle.
//     -> measurement restarts from IDLE.
//  6. Single-cycle high glitch on clk_sample -> exactly one rise_strobe and one
//     fall_strobe. Both are delayed SYNC_STAGES+1 cycles and are never simultaneous.

Source files
------------

// File: rtl/clock_edge_monitor.sv
// -----------------------------------------------------------------------------
// clock_edge_monitor
//
// Receive-side companion to the clock divider. A divided clock (clk_sample) is
// brought into the clock_in domain through a flop synchronizer. The block then:
//   - emits single-cycle rise/fall strobes for downstream clock-enable logic,
//   - measures the rise-to-rise period of clk_sample in clock_in cycles,
//   - declares lock once LOCK_COUNT consecutive periods agree within TOLERANCE,
//   - pulses timeout when no rising edge is seen for TIMEOUT clock_in cycles.
//
// Ports
//   clock_in      in   1          fast system clock
//   aresetn       in   1          synchronous, active-low reset
//   clk_sample    in   1          divided clock to monitor (async to clock_in)
//   rise_strobe   out  1          1-cycle pulse per synchronized rising edge
//   fall_strobe   out  1          1-cycle pulse per synchronized falling edge
//   period        out  CNT_WIDTH  last measured rise-to-rise period
//   period_valid  out  1          1-cycle pulse when period is updated
//   ref_period    out  CNT_WIDTH  period currently being locked/held
//   locked        out  1          high while in the LOCKED state
//   timeout       out  1          1-cycle pulse when TIMEOUT is reached
// -----------------------------------------------------------------------------
module clock_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clock_in,
    input  logic                 aresetn,
    input  logic                 clk_sample,
    output logic                 rise_strobe,
    output logic                 fall_strobe,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic [CNT_WIDTH-1:0] ref_period,
    output logic                 locked,
    output logic                 timeout
);

    // match_cnt must be able to hold LOCK_COUNT plus one increment.
    localparam int MC_W = $clog2(LOCK_COUNT + 1) + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] TOL_C      = CNT_WIDTH'(TOLERANCE);
    localparam logic [MC_W-1:0]      MC_ZERO    = {MC_W{1'b0}};
    localparam logic [MC_W-1:0]      MC_ONE     = MC_W'(1);
    localparam logic [MC_W-1:0]      LOCK_C     = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Unsigned distance between two periods, never wrapping.
    function automatic logic [CNT_WIDTH-1:0] abs_diff(
        input logic [CNT_WIDTH-1:0] a,
        input logic [CNT_WIDTH-1:0] b
    );
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // Registers and their next-state values
    logic [SYNC_STAGES-1:0] sync_q,         sync_d;
    logic                   s_dly_q,        s_dly_d;
    logic [CNT_WIDTH-1:0]   cnt_q,          cnt_d;
    logic [CNT_WIDTH-1:0]   period_q,       period_d;
    logic [CNT_WIDTH-1:0]   ref_period_q,   ref_period_d;
    logic [MC_W-1:0]        match_cnt_q,    match_cnt_d;
    logic                   first_seen_q,   first_seen_d;
    state_t                 state_q,        state_d;
    logic                   rise_strobe_q,  rise_strobe_d;
    logic                   fall_strobe_q,  fall_strobe_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q,       locked_d;
    logic                   timeout_q,      timeout_d;

    // Combinational helpers
    logic                   s_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   timeout_hit_s;
    logic                   match_s;
    logic [MC_W-1:0]        mc_inc_s;

    assign s_s      = sync_q[SYNC_STAGES-1];
    assign rise_s   = s_s & ~s_dly_q;
    assign fall_s   = ~s_s & s_dly_q;
    // A rise in the same cycle wins over the timeout condition.
    assign timeout_hit_s = (cnt_q == TIMEOUT_M1) && !rise_s;
    // Match is judged on the registered period, i.e. in the period_valid cycle.
    assign match_s  = (abs_diff(period_q, ref_period_q) <= TOL_C);
    assign mc_inc_s = match_cnt_q + MC_ONE;

    // Next-state logic: edge detect, period counter and lock state machine
    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], clk_sample};
        s_dly_d        = s_s;
        cnt_d          = cnt_q;
        period_d       = period_q;
        ref_period_d   = ref_period_q;
        match_cnt_d    = match_cnt_q;
        first_seen_d   = first_seen_q;
        state_d        = state_q;
        locked_d       = locked_q;
        rise_strobe_d  = rise_s;
        fall_strobe_d  = fall_s;
        period_valid_d = rise_s & first_seen_q;
        timeout_d      = timeout_hit_s;

        // Rise-to-rise counter, saturating so an absent clock cannot wrap it
        if (rise_s) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (rise_s && first_seen_q) begin
            period_d = cnt_q;
        end else begin
            period_d = period_q;
        end

        if (timeout_hit_s) begin
            // Loss of clock: forget lock progress but keep the last measurements
            state_d      = ST_IDLE;
            locked_d     = 1'b0;
            first_seen_d = 1'b0;
            match_cnt_d  = MC_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_d      = ST_ACQUIRE;
                        first_seen_d = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                    end
                end
                ST_ACQUIRE: begin
                    if (period_valid_q) begin
                        if (match_s) begin
                            match_cnt_d = mc_inc_s;
                            if (mc_inc_s >= LOCK_C) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d  = ST_ACQUIRE;
                            end
                        end else begin
                            // New candidate period; it counts as the first sample
                            ref_period_d = period_q;
                            match_cnt_d  = MC_ONE;
                        end
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (period_valid_q && !match_s) begin
                        state_d      = ST_ACQUIRE;
                        locked_d     = 1'b0;
                        ref_period_d = period_q;
                        match_cnt_d  = MC_ONE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    locked_d     = 1'b0;
                    first_seen_d = 1'b0;
                    match_cnt_d  = MC_ZERO;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock_in) begin
        if (!aresetn) begin
            sync_q         <= {SYNC_STAGES{1'b0}};
            s_dly_q        <= 1'b0;
            cnt_q          <= CNT_ZERO;
            period_q       <= CNT_ZERO;
            ref_period_q   <= CNT_ZERO;
            match_cnt_q    <= MC_ZERO;
            first_seen_q   <= 1'b0;
            state_q        <= ST_IDLE;
            rise_strobe_q  <= 1'b0;
            fall_strobe_q  <= 1'b0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            s_dly_q        <= s_dly_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            ref_period_q   <= ref_period_d;
            match_cnt_q    <= match_cnt_d;
            first_seen_q   <= first_seen_d;
            state_q        <= state_d;
            rise_strobe_q  <= rise_strobe_d;
            fall_strobe_q  <= fall_strobe_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign rise_strobe  = rise_strobe_q;
    assign fall_strobe  = fall_strobe_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign ref_period   = ref_period_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_edge_monitor
//
// Directed bench for clock_edge_monitor. Two instances share clk_sample:
// dut (TOLERANCE=0) and dut2 (TOLERANCE=1). Stimulus is driven on the falling
// edge of clock_in; a monitor samples outputs 1 ns after each rising edge and
// keeps event counters; checks are made on falling edges.
// -----------------------------------------------------------------------------
module tb_clock_edge_monitor;

    logic        clock_in   = 1'b0;
    logic        aresetn    = 1'b0;
    logic        clk_sample = 1'b0;

    logic        rise_strobe, fall_strobe, period_valid, locked, timeout;
    logic [15:0] period, ref_period;
    logic        d2_rise_strobe, d2_fall_strobe, d2_period_valid, d2_locked, d2_timeout;
    logic [15:0] d2_period, d2_ref_period;

    always #5 clock_in = ~clock_in;

    clock_edge_monitor #(
        .SYNC_STAGES(2), .CNT_WIDTH(16), .LOCK_COUNT(4), .TOLERANCE(0), .TIMEOUT(1024)
    ) dut (
        .clock_in(clock_in), .aresetn(aresetn), .clk_sample(clk_sample),
        .rise_strobe(rise_strobe), .fall_strobe(fall_strobe),
        .period(period), .period_valid(period_valid), .ref_period(ref_period),
        .locked(locked), .timeout(timeout)
    );

    clock_edge_monitor #(
        .SYNC_STAGES(2), .CNT_WIDTH(16), .LOCK_COUNT(4), .TOLERANCE(1), .TIMEOUT(1024)
    ) dut2 (
        .clock_in(clock_in), .aresetn(aresetn), .clk_sample(clk_sample),
        .rise_strobe(d2_rise_strobe), .fall_strobe(d2_fall_strobe),
        .period(d2_period), .period_valid(d2_period_valid), .ref_period(d2_ref_period),
        .locked(d2_locked), .timeout(d2_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Event counters maintained by the monitor
    int cyc = 0, rise_cnt = 0, fall_cnt = 0, both_cnt = 0, pv_cnt = 0, to_cnt = 0;
    int last_rise_cyc = 0, last_fall_cyc = 0, to_cyc = 0;
    int lock_rise_at = 0, lock_fall_at = 0, d2_drop_cnt = 0;
    logic locked_prev = 1'b0, d2_locked_prev = 1'b0;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_in);
    endtask

    // One clk_sample period of p cycles: high for p/2, low for the rest
    task automatic drive_wave(input int p);
        for (int i = 0; i < p; i++) begin
            clk_sample = (i < p / 2) ? 1'b1 : 1'b0;
            @(negedge clock_in);
        end
    endtask

    // One-cycle reset pulse; returns on the falling edge after the reset edge
    task automatic do_reset();
        clk_sample = 1'b0;
        aresetn    = 1'b0;
        @(negedge clock_in);
        aresetn    = 1'b1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_value({pfx, "_rise"},   int'(rise_strobe),  0);
        check_value({pfx, "_fall"},   int'(fall_strobe),  0);
        check_value({pfx, "_period"}, int'(period),       0);
        check_value({pfx, "_pv"},     int'(period_valid), 0);
        check_value({pfx, "_ref"},    int'(ref_period),   0);
        check_value({pfx, "_locked"}, int'(locked),       0);
        check_value({pfx, "_timeout"},int'(timeout),      0);
    endtask

    // Output monitor, sampling 1 ns after each rising edge
    initial begin
        forever begin
            @(posedge clock_in);
            #1;
            cyc++;
            if (rise_strobe === 1'b1) begin rise_cnt++; last_rise_cyc = cyc; end
            if (fall_strobe === 1'b1) begin fall_cnt++; last_fall_cyc = cyc; end
            if (rise_strobe === 1'b1 && fall_strobe === 1'b1) both_cnt++;
            if (period_valid === 1'b1) pv_cnt++;
            if (timeout === 1'b1) begin to_cnt++; to_cyc = cyc; end
            if (locked === 1'b1 && locked_prev == 1'b0) lock_rise_at = rise_cnt;
            if (locked === 1'b0 && locked_prev == 1'b1) lock_fall_at = rise_cnt;
            locked_prev = (locked === 1'b1);
            if (d2_locked === 1'b0 && d2_locked_prev == 1'b1) d2_drop_cnt++;
            d2_locked_prev = (d2_locked === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int r0, f0, pv0, to0, gc, d2d0;
        bit found;

        // Reset state
        aresetn    = 1'b0;
        clk_sample = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        check_all_zero("reset");

        // Single-cycle glitch: one rise, one fall, SYNC_STAGES+1 latency, never together
        r0 = rise_cnt; f0 = fall_cnt; pv0 = pv_cnt; gc = cyc;
        clk_sample = 1'b1;
        tick();
        clk_sample = 1'b0;
        repeat (6) tick();
        check_value("glitch_rises",   rise_cnt - r0, 1);
        check_value("glitch_falls",   fall_cnt - f0, 1);
        check_value("glitch_latency", last_rise_cyc - gc, 3);
        check_value("glitch_fall_after_rise", last_fall_cyc - last_rise_cyc, 1);
        check_value("glitch_no_pv",   pv_cnt - pv0, 0);

        // Period 4: lock on the 5th rise (first rise + 4 measured periods)
        do_reset();
        r0 = rise_cnt; pv0 = pv_cnt;
        repeat (4) drive_wave(4);
        check_value("p4_pv_count", pv_cnt - pv0, 3);
        check_value("p4_period",   int'(period), 4);
        check_value("p4_ref",      int'(ref_period), 4);
        check_value("p4_not_yet_locked", int'(locked), 0);
        repeat (2) drive_wave(4);
        check_value("p4_locked",   int'(locked), 1);
        check_value("p4_lock_rise_index", lock_rise_at - r0, 5);

        // Period changes to 6: lock drops, relocks 3 rises after the drop
        repeat (2) drive_wave(6);
        check_value("p6_unlocked", int'(locked), 0);
        check_value("p6_ref",      int'(ref_period), 6);
        check_value("p6_period",   int'(period), 6);
        repeat (4) drive_wave(6);
        check_value("p6_relocked", int'(locked), 1);
        check_value("p6_relock_gap", lock_rise_at - lock_fall_at, 3);

        // Clock stops: timeout pulse TIMEOUT cycles after the last internal rise,
        // which is TIMEOUT-1 cycles after the (one-cycle-delayed) rise_strobe
        clk_sample = 1'b0;
        to0 = to_cnt;
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            tick();
            if (to_cnt != to0) found = 1'b1;
        end
        check_value("to_seen",    to_cnt - to0, 1);
        check_value("to_distance", to_cyc - last_rise_cyc, 1023);
        check_value("to_pulse_high", int'(timeout), 1);
        check_value("to_unlocked", int'(locked), 0);
        check_value("to_period_kept", int'(period), 6);
        check_value("to_ref_kept",    int'(ref_period), 6);
        tick();
        check_value("to_pulse_single", int'(timeout), 0);
        pv0 = pv_cnt;
        drive_wave(6);
        check_value("to_first_rise_no_pv", pv_cnt - pv0, 0);
        repeat (6) drive_wave(6);
        check_value("to_relocked", int'(locked), 1);

        // Reset while locked: all outputs cleared, measurement restarts from IDLE
        do_reset();
        check_all_zero("midreset");
        r0 = rise_cnt; pv0 = pv_cnt;
        drive_wave(5);
        check_value("midreset_first_no_pv", pv_cnt - pv0, 0);
        repeat (5) drive_wave(5);
        check_value("midreset_locked", int'(locked), 1);
        check_value("midreset_ref",    int'(ref_period), 5);
        check_value("midreset_lock_rise_index", lock_rise_at - r0, 5);

        // Jitter 7/8: TOLERANCE=1 instance locks and holds ref 7; TOLERANCE=0 never locks
        do_reset();
        d2d0 = d2_drop_cnt;
        repeat (4) begin
            drive_wave(7);
            drive_wave(8);
        end
        check_value("jit_d2_locked", int'(d2_locked), 1);
        check_value("jit_d2_ref",    int'(d2_ref_period), 7);
        check_value("jit_d2_no_drop", d2_drop_cnt - d2d0, 0);
        check_value("jit_tol0_unlocked", int'(locked), 0);
        // Period 9 is 2 away from ref 7: beyond tolerance, lock drops
        repeat (2) drive_wave(9);
        check_value("jit_d2_drop", int'(d2_locked), 0);
        check_value("jit_d2_newref", int'(d2_ref_period), 9);

        check_value("never_simultaneous", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
